dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Parametrised data-memory controller for the processor data bus.
- Single-port word RAM with a configurable base and depth, and a valid/ready request/response handshake.
- Supports byte, half and word loads/stores with sign or zero extension, plus address-range and alignment checking.
- Sits between the load/store stage and the data bus; out-of-window accesses return an error instead of aliasing.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH_LOG2, 11, log2 of the number of 32-bit words (N_WORDS = 1<<DEPTH_LOG2).
- BASE_ADDR, 32'h00000000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response held.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  range, alignment or size error for this response.
- resp_par_err  out  1  parity error; only driven when DMEM_PARITY_EN is defined, else tied 0.

Behaviour:
- Reset (async, active-high):
  - resp_valid=0, resp_rdata=0, resp_err=0, resp_par_err=0, FSM=IDLE.
  - RAM contents are not reset.
  - Reset while in RESP discards the pending response; a store already accepted has been committed.
- FSM:
  - IDLE: req_ready=1.
  - RESP: resp_valid=1; req_ready=resp_ready.
- Accept: a request is accepted on any posedge where req_valid && req_ready.
  - The RAM write and the RAM read both happen on that edge.
  - Next state is RESP, so load latency is exactly 1 cycle (response visible the cycle after accept).
- RESP, resp_ready=1:
  - Response retires on the next edge.
  - If a new request is accepted on the same edge, the FSM stays in RESP with the new response, so back-to-back throughput is 1 per cycle.
  - Otherwise the FSM returns to IDLE.
- RESP, resp_ready=0: all resp_* outputs hold stable, and no request is accepted.
- Decode:
  - off = req_addr - BASE_ADDR, computed in ADDR_W bits.
  - In range iff req_addr >= BASE_ADDR and off < (N_WORDS<<2).
  - Word index = off[DEPTH_LOG2+1:2]; lane = off[1:0].
- Error conditions, set resp_err=1:
  - out of range;
  - req_size=3;
  - half with lane[0]=1;
  - word with lane != 0.
- On error: no RAM write and resp_rdata=0. The error response still completes the handshake normally.
- Store: byte-lane write enables are derived from size and lane; write data is replicated into the selected lanes; unselected bytes are unchanged.
- Load: selected lane(s) are shifted to bit 0, then extended per req_unsigned. Word loads ignore req_unsigned.
- Store responses carry resp_rdata=0 and resp_err as computed.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte (4 extra RAM bits per word) and updated with each byte-lane write.
  - On a load, any addressed byte whose stored parity mismatches sets resp_par_err=1 with the response. Data is still returned and resp_err is unaffected.
  - Non-addressed bytes are not checked.
- Not defined: no parity storage, and resp_par_err is constant 0.

Test Plan:
- Word round trip, BASE_ADDR=32'h1000:
  - Store word 32'hDEADBEEF to 32'h1004, then load word from 32'h1004.
  - Required: resp_rdata=32'hDEADBEEF exactly 1 cycle after accept, resp_err=0.
- Byte store and extended loads, after the word round trip:
  - Store byte 8'h80 to 32'h1005.
  - Signed byte load from 32'h1005 returns 32'hFFFFFF80.
  - Unsigned byte load from 32'h1005 returns 32'h00000080.
  - Word load from 32'h1004 returns 32'hDEAD80EF.
- Range and alignment errors:
  - Load from 32'h0FFC: resp_err=1, rdata=0.
  - Load from 32'h1000+(N_WORDS<<2): resp_err=1, rdata=0.
  - Half store to 32'h1001: resp_err=1, and memory is unchanged on a subsequent word read.
- Backpressure:
  - Hold resp_ready=0 for 3 cycles after a load.
  - Required: resp_* stable, req_ready=0, a second pending request not accepted.
  - Raise resp_ready: second request accepted on the same edge, and its response follows the next cycle.
- Streaming: 8 back-to-back word loads with resp_ready=1 complete in 9 cycles, with responses in order.
- Reset mid-response: assert reset while resp_valid=1 and resp_ready=0.
  - Required: resp_valid drops immediately (async), FSM returns to IDLE.
  - The previously stored data is still readable after reset release.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-port word RAM behind a valid/ready request/response handshake.
// Optional per-byte even parity is enabled by defining DMEM_PARITY_EN.
module dmem_ctrl #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_par_err
);

    localparam int unsigned       N_WORDS   = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(N_WORDS) << 2;

    typedef enum logic {StIdle, StResp} state_e;

    state_e          state_q, state_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [31:0]           mem_q [N_WORDS];
    logic [ADDR_W-1:0]     off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic                  err;
    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_data;
    logic                  accept;

    // Address decode, error detection and lane steering
    always_comb begin
        off       = req_addr - BASE_ADDR;
        in_range  = (req_addr >= BASE_ADDR) && (off < MEM_BYTES);
        idx       = off[DEPTH_LOG2+1:2];
        lane      = off[1:0];
        err       = !in_range;
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                err       = err | lane[0];
                be        = 4'b0011 << lane;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                err = err | (lane != 2'd0);
                be  = 4'b1111;
            end
            default: err = 1'b1;
        endcase

        rd_word = mem_q[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{lane[1], 4'b0000} +: 16];
        case (req_size)
            2'd0:    load_data = req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    load_data = req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
        if (err || req_we) begin
            load_data = 32'b0;
        end
    end

    assign req_ready = (state_q == StIdle) || resp_ready;
    assign accept    = req_valid && req_ready;

    // RAM contents survive reset, so the array has no reset branch
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_q [N_WORDS];
    logic       par_bad;
    logic       resp_par_err_q, resp_par_err_d;

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    par_q[idx][i] <= ^wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Only the bytes this load actually addresses are checked
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (be[i] && (par_q[idx][i] != ^rd_word[8*i +: 8])) begin
                par_bad = 1'b1;
            end
        end
        resp_par_err_d = resp_par_err_q;
        if (accept) begin
            resp_par_err_d = !req_we && !err && par_bad;
        end else if ((state_q == StResp) && resp_ready) begin
            resp_par_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_par_err_q <= 1'b0;
        end else begin
            resp_par_err_q <= resp_par_err_d;
        end
    end

    assign resp_par_err = resp_par_err_q;
`else
    assign resp_par_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            state_d      = StResp;
            resp_rdata_d = load_data;
            resp_err_d   = err;
        end else if ((state_q == StResp) && resp_ready) begin
            state_d      = StIdle;
            resp_rdata_d = 32'b0;
            resp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
